// File: rtl/gun_pkg.sv
// Shared types and parameter defaults for the light-gun hit detector.
package gun_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    WHITE,
    COOLDOWN
  } gun_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 650000;
  localparam int DETECT_MIN_DEFAULT      = 64;
  localparam int COOLDOWN_FRAMES_DEFAULT = 15;

endpackage

// File: rtl/gun_debounce.sv
// Trigger conditioning: 2-FF synchronizer, stable-sample debouncer and a
// registered one-cycle pulse on each 0->1 change of the debounced level.
module gun_debounce
  import gun_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The counter tracks how many consecutive samples disagree with the
  // current level; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      rise       <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_2 != level) begin
        if (stable_cnt == LAST) begin
          level      <= sync_2;
          stable_cnt <= '0;
          rise       <= sync_2;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gun_hit_detector.sv
// Duck Hunt shot evaluator: flashes one black frame then one white-target
// frame after a trigger press and decides hit/miss from photodetector light.
module gun_hit_detector
  import gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int DETECT_MIN      = DETECT_MIN_DEFAULT,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic new_frame,
  input  logic gun_trigger,
  input  logic gun_photodetector,
  input  logic duck_show,
  output logic screen_black,
  output logic target_white,
  output logic shot_fired,
  output logic duck_hit,
  output logic busy
);

  localparam int LW = $clog2(DETECT_MIN + 1);
  localparam int FW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [LW-1:0] LIGHT_FULL = LW'(DETECT_MIN);
  localparam logic [FW-1:0] FRAME_LAST = FW'(COOLDOWN_FRAMES - 1);

  gun_state_t    state;
  gun_state_t    next_state;
  logic          press;
  logic          photo_1;
  logic          photo_2;
  logic [LW-1:0] light_cnt;
  logic [FW-1:0] frame_cnt;
  logic          black_lit;
  logic          light_seen;
  logic          black_next;
  logic          white_next;
  logic          busy_next;
  logic          shot_next;
  logic          hit_next;

  gun_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_trigger (
    .clk (clk),
    .rst (rst),
    .raw (gun_trigger),
    .rise(press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      photo_1 <= 1'b0;
      photo_2 <= 1'b0;
    end else begin
      photo_1 <= gun_photodetector;
      photo_2 <= photo_1;
    end
  end

  assign light_seen = (light_cnt == LIGHT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      screen_black <= 1'b0;
      target_white <= 1'b0;
      busy         <= 1'b0;
      shot_fired   <= 1'b0;
      duck_hit     <= 1'b0;
    end else begin
      state        <= next_state;
      screen_black <= black_next;
      target_white <= white_next;
      busy         <= busy_next;
      shot_fired   <= shot_next;
      duck_hit     <= hit_next;
    end
  end

  // A press that lands on new_frame only reaches ARM, so BLACK always
  // starts on the following frame boundary and covers a whole frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (press) next_state = duck_show ? ARM : COOLDOWN;
      ARM:      if (new_frame) next_state = BLACK;
      BLACK:    if (new_frame) next_state = WHITE;
      WHITE:    if (new_frame) next_state = COOLDOWN;
      COOLDOWN: if (new_frame && frame_cnt == FRAME_LAST) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    black_next = (next_state == BLACK);
    white_next = (next_state == WHITE);
    busy_next  = (next_state != IDLE);
    shot_next  = (state == IDLE) && press;
    hit_next   = (state == WHITE) && new_frame && light_seen && !black_lit;
  end

  // The sample taken on the boundary cycle opens the new window's count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_cnt <= '0;
      frame_cnt <= '0;
      black_lit <= 1'b0;
    end else begin
      if ((next_state == BLACK && state != BLACK) ||
          (next_state == WHITE && state != WHITE)) begin
        light_cnt <= LW'(photo_2);
      end else if (photo_2 && !light_seen) begin
        light_cnt <= light_cnt + 1'b1;
      end

      if (state == BLACK && new_frame) begin
        black_lit <= light_seen;
      end

      if (next_state == COOLDOWN && state != COOLDOWN) begin
        frame_cnt <= '0;
      end else if (state == COOLDOWN && new_frame) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gun_hit_detector.sv
// Directed bench for gun_hit_detector with an event scoreboard: expected
// output events (kind and cycle) are queued as each press is driven.
module tb_gun_hit_detector;

  localparam int DEB   = 4;
  localparam int DMIN  = 4;
  localparam int CDF   = 2;
  localparam int FRAME = 100;

  localparam int M_NONE     = 0;
  localparam int M_MISS     = 1;
  localparam int M_HIT      = 2;
  localparam int M_NODUCK   = 3;
  localparam int M_TO_WHITE = 4;

  typedef enum int {
    EV_SHOT, EV_BLACK_RISE, EV_BLACK_FALL, EV_WHITE_RISE,
    EV_WHITE_FALL, EV_HIT, EV_BUSY_FALL
  } ev_t;

  typedef struct {
    ev_t kind;
    int  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic new_frame = 1'b0;
  logic gun_trigger = 1'b0;
  logic gun_photodetector = 1'b0;
  logic duck_show = 1'b0;
  logic screen_black;
  logic target_white;
  logic shot_fired;
  logic duck_hit;
  logic busy;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  exp_t sb[$];
  logic prev_black = 1'b0;
  logic prev_white = 1'b0;
  logic prev_busy  = 1'b0;

  gun_hit_detector #(
    .DEBOUNCE_CYCLES(DEB),
    .DETECT_MIN     (DMIN),
    .COOLDOWN_FRAMES(CDF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .new_frame        (new_frame),
    .gun_trigger      (gun_trigger),
    .gun_photodetector(gun_photodetector),
    .duck_show        (duck_show),
    .screen_black     (screen_black),
    .target_white     (target_white),
    .shot_fired       (shot_fired),
    .duck_hit         (duck_hit),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // new_frame is sampled by the DUT on every edge whose number is a multiple of FRAME.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      new_frame = (cyc % FRAME == FRAME - 1);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void push(input ev_t k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endfunction

  function automatic int next_frame(input int e);
    return ((e / FRAME) + 1) * FRAME;
  endfunction

  task automatic observe(input ev_t kind);
    exp_t e;
    check({kind.name(), "_expected"}, (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({kind.name(), "_kind"}, int'(kind), int'(e.kind));
      check({kind.name(), "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (shot_fired)                   observe(EV_SHOT);
    if (screen_black && !prev_black)  observe(EV_BLACK_RISE);
    if (!screen_black && prev_black)  observe(EV_BLACK_FALL);
    if (target_white && !prev_white)  observe(EV_WHITE_RISE);
    if (!target_white && prev_white)  observe(EV_WHITE_FALL);
    if (duck_hit)                     observe(EV_HIT);
    if (!busy && prev_busy)           observe(EV_BUSY_FALL);
    prev_black = screen_black;
    prev_white = target_white;
    prev_busy  = busy;
  end

  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a trigger press and queues the events it must cause.
  task automatic apply_press(input int hold, input int mode, output int f1);
    int p;
    int s;
    @(posedge clk);
    #1;
    p  = cyc;
    s  = p + DEB + 3;
    f1 = next_frame(s);
    if (mode != M_NONE) push(EV_SHOT, s);
    if (mode == M_NODUCK) push(EV_BUSY_FALL, f1 + FRAME * (CDF - 1));
    if (mode == M_MISS || mode == M_HIT || mode == M_TO_WHITE) begin
      push(EV_BLACK_RISE, f1);
      push(EV_BLACK_FALL, f1 + FRAME);
      push(EV_WHITE_RISE, f1 + FRAME);
    end
    if (mode == M_MISS || mode == M_HIT) begin
      push(EV_WHITE_FALL, f1 + 2 * FRAME);
      if (mode == M_HIT) push(EV_HIT, f1 + 2 * FRAME);
      push(EV_BUSY_FALL, f1 + 2 * FRAME + FRAME * CDF);
    end
    gun_trigger = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    gun_trigger = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int f1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #20;
    check("reset_screen_black", int'(screen_black), 0);
    check("reset_target_white", int'(target_white), 0);
    check("reset_shot_fired", int'(shot_fired), 0);
    check("reset_duck_hit", int'(duck_hit), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (5) @(posedge clk);

    // Hit: light only in the white frame.
    duck_show = 1'b1;
    apply_press(10, M_HIT, f1);
    @(negedge clk);
    check("hit_busy_armed", int'(busy), 1);
    wait_cycle(f1 + FRAME + 20);
    gun_photodetector = 1'b1;
    wait_cycle(f1 + FRAME + 40);
    gun_photodetector = 1'b0;
    drain("hit", 800);

    // Miss: no light at all.
    apply_press(10, M_MISS, f1);
    drain("miss", 800);

    // Lamp: constant light makes black_lit and forces a miss.
    gun_photodetector = 1'b1;
    apply_press(10, M_MISS, f1);
    drain("lamp", 800);
    gun_photodetector = 1'b0;

    // Bounce: short pulses never satisfy the debouncer.
    duck_show = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      gun_trigger = ((i / 2) % 2 == 0);
      @(posedge clk);
      #1;
    end
    gun_trigger = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_idle", int'(busy), 0);

    // Held 6 cycles with no duck: one shot, cooldown only, second press ignored.
    apply_press(6, M_NODUCK, f1);
    repeat (30) @(negedge clk);
    check("noduck_busy", int'(busy), 1);
    check("noduck_no_black", int'(screen_black), 0);
    apply_press(10, M_NONE, f1);
    repeat (3) @(negedge clk);
    check("noduck_no_white", int'(target_white), 0);
    drain("noduck", 500);

    // Reset in the middle of the white frame with light present.
    duck_show = 1'b1;
    apply_press(10, M_TO_WHITE, f1);
    wait_cycle(f1 + FRAME + 10);
    gun_photodetector = 1'b1;
    wait_cycle(f1 + FRAME + 30);
    gun_photodetector = 1'b0;
    wait_cycle(f1 + FRAME + 50);
    push(EV_WHITE_FALL, f1 + FRAME + 50);
    push(EV_BUSY_FALL, f1 + FRAME + 50);
    #2 rst = 1'b0;
    #1;
    check("rst_white_async", int'(target_white), 0);
    check("rst_busy_async", int'(busy), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    wait_cycle(f1 + 2 * FRAME + 60);
    check("rst_stays_idle", int'(busy), 0);
    drain("rst", 20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
